// File: rtl/score_accum_serial_if.sv
// Event handshake and adder-stage signals for the nibble-serial score accumulator.
// The accumulator is the slave; the event source and the external adder form the master side.
interface score_accum_serial_if #(
    parameter int NIBBLES = 4
);
    logic                   score_clr;
    logic                   evt_valid;
    logic                   evt_ready;
    logic                   evt_sub;
    logic [3:0]             evt_pts;
    logic [3:0]             add_a;
    logic [3:0]             add_b;
    logic                   add_cin;
    logic [3:0]             add_s;
    logic                   add_cout;
    logic [4*NIBBLES-1:0]   score;
    logic                   done;
    logic                   sat;

    modport slave (
        input  score_clr, evt_valid, evt_sub, evt_pts, add_s, add_cout,
        output evt_ready, add_a, add_b, add_cin, score, done, sat
    );

    modport master (
        output score_clr, evt_valid, evt_sub, evt_pts, add_s, add_cout,
        input  evt_ready, add_a, add_b, add_cin, score, done, sat
    );
endinterface

// File: rtl/score_accum_serial.sv
// Nibble-serial saturating score accumulator: one nibble per cycle through an external
// 4-bit adder, committing the clamped result on the last nibble.
module score_accum_serial #(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    score_accum_serial_if.slave   bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t         r_state;
    logic [KW-1:0]  r_k;
    logic           r_sub;
    logic           r_carry;
    logic           r_done;
    logic           r_sat;
    logic [W-1:0]   r_op;
    logic [W-1:0]   r_res;
    logic [W-1:0]   r_score;

    logic [W-1:0]   w_res;
    logic           w_last;

    assign w_last        = (r_k == K_LAST);
    assign bus.evt_ready = (r_state == IDLE);
    assign bus.score     = r_score;
    assign bus.done      = r_done;
    assign bus.sat       = r_sat;

    // Partial result with the nibble being computed this cycle already merged in.
    always_comb begin
        w_res = r_res;
        w_res[4*r_k +: 4] = bus.add_s;
    end

    always_comb begin
        bus.add_a   = 4'h0;
        bus.add_b   = 4'h0;
        bus.add_cin = 1'b0;
        if (r_state == RUN) begin
            bus.add_a   = r_score[4*r_k +: 4];
            bus.add_b   = r_op[4*r_k +: 4] ^ {4{r_sub}};
            bus.add_cin = (r_k == '0) ? r_sub : r_carry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_done  <= 1'b0;
            r_sat   <= 1'b0;
            r_op    <= '0;
            r_res   <= '0;
            r_score <= '0;
        end else if (bus.score_clr) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_carry <= 1'b0;
            r_done  <= 1'b0;
            r_sat   <= 1'b0;
            r_score <= '0;
        end else begin
            r_done <= 1'b0;
            r_sat  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.evt_valid) begin
                        r_sub   <= bus.evt_sub;
                        r_op    <= W'(bus.evt_pts);
                        r_k     <= '0;
                        r_carry <= 1'b0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_res   <= w_res;
                    r_carry <= bus.add_cout;
                    r_k     <= r_k + 1'b1;
                    if (w_last) begin
                        r_state <= IDLE;
                        r_k     <= '0;
                        r_done  <= 1'b1;
                        // Carry out of an add overflows; missing carry out of a subtract is a borrow.
                        if (!r_sub && bus.add_cout) begin
                            r_score <= '1;
                            r_sat   <= 1'b1;
                        end else if (r_sub && !bus.add_cout) begin
                            r_score <= '0;
                            r_sat   <= 1'b1;
                        end else begin
                            r_score <= w_res;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_score_accum_serial.sv
// Directed plus randomized bench for score_accum_serial with a behavioural saturating score model.
module tb_score_accum_serial;
    localparam int NIB  = 4;
    localparam int MAXS = (1 << (4*NIB)) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   m_score = 0;

    score_accum_serial_if #(.NIBBLES(NIB)) bus ();

    score_accum_serial #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural 4-bit adder standing in for the external ripple stage.
    assign {bus.add_cout, bus.add_s} = 5'(bus.add_a) + 5'(bus.add_b) + 5'(bus.add_cin);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.evt_ready !== 1'b1 && n < 20) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 32'(bus.evt_ready), 32'd1);
    endtask

    // One full event: handshake, busy window, commit cycle, and pulse width.
    task automatic do_event(input bit sub, input int pts);
        int exp_s;
        bit exp_sat;
        logic [3:0] busy;
        wait_ready();
        if (sub) begin
            exp_sat = (pts > m_score);
            exp_s   = exp_sat ? 0 : m_score - pts;
        end else begin
            exp_sat = (m_score + pts > MAXS);
            exp_s   = exp_sat ? MAXS : m_score + pts;
        end
        bus.evt_valid = 1'b1;
        bus.evt_sub   = sub;
        bus.evt_pts   = 4'(pts);
        @(posedge clk); @(negedge clk);
        bus.evt_valid = 1'b0;
        bus.evt_sub   = 1'($urandom);
        bus.evt_pts   = 4'($urandom);
        busy = '0;
        for (int i = 0; i < 4; i++) begin
            if (bus.evt_ready !== 1'b0 || bus.done !== 1'b0) busy[i] = 1'b1;
            if (i < 3) begin @(posedge clk); @(negedge clk); end
        end
        chk("busy_window", 32'(busy), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("done", 32'(bus.done), 32'd1);
        chk("sat", 32'(bus.sat), 32'(exp_sat));
        chk("score", 32'(bus.score), 32'(exp_s));
        chk("ready_after", 32'(bus.evt_ready), 32'd1);
        m_score = exp_s;
        @(posedge clk); @(negedge clk);
        chk("done_width", 32'({bus.done, bus.sat}), 32'd0);
    endtask

    task automatic do_clear();
        bus.score_clr = 1'b1;
        bus.evt_valid = 1'b1;
        bus.evt_sub   = 1'b0;
        bus.evt_pts   = 4'd1;
        @(posedge clk); @(negedge clk);
        bus.score_clr = 1'b0;
        bus.evt_valid = 1'b0;
        chk("clr_score", 32'(bus.score), 32'd0);
        chk("clr_not_accepted", 32'(bus.evt_ready), 32'd1);
        m_score = 0;
    endtask

    task automatic set_score(input int target);
        if (target < m_score) do_clear();
        while (m_score < target)
            do_event(1'b0, (target - m_score > 15) ? 15 : target - m_score);
    endtask

    initial begin
        logic [14:0] rdy_obs, rdy_exp;
        int acc, dcount;
        bus.score_clr = 1'b0;
        bus.evt_valid = 1'b0;
        bus.evt_sub   = 1'b0;
        bus.evt_pts   = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_ready", 32'(bus.evt_ready), 32'd1);
        chk("rst_score", 32'(bus.score), 32'd0);
        chk("rst_pulses", 32'({bus.done, bus.sat}), 32'd0);
        chk("idle_adder", 32'({bus.add_a, bus.add_b, bus.add_cin}), 32'd0);

        do_event(1'b0, 9);
        chk("add9", 32'(bus.score), 32'h0009);
        set_score(16'h00FF);
        do_event(1'b0, 1);
        chk("ripple", 32'(bus.score), 32'h0100);
        set_score(16'hFFF8);
        do_event(1'b0, 15);
        chk("sat_hi", 32'(bus.score), 32'hFFFF);
        set_score(3);
        do_event(1'b1, 5);
        chk("sat_lo", 32'(bus.score), 32'h0000);
        set_score(16'h1000);
        do_event(1'b1, 1);
        chk("borrow", 32'(bus.score), 32'h0FFF);
        do_event(1'b1, 0);
        chk("sub0", 32'(bus.score), 32'h0FFF);

        // Continuous valid: accepts at cycles 0, 5, 10.
        wait_ready();
        bus.evt_valid = 1'b1; bus.evt_sub = 1'b0; bus.evt_pts = 4'd1;
        rdy_obs = '0; rdy_exp = '0; acc = 0; dcount = 0;
        for (int c = 0; c < 15; c++) begin
            rdy_obs[c] = bus.evt_ready;
            rdy_exp[c] = (c % 5 == 0);
            if (bus.done === 1'b1) dcount++;
            @(posedge clk); @(negedge clk);
        end
        bus.evt_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (bus.done === 1'b1) dcount++;
            @(posedge clk); @(negedge clk);
        end
        chk("stream_ready", 32'(rdy_obs), 32'(rdy_exp));
        chk("stream_done", 32'(dcount), 32'd3);
        m_score = m_score + 3;
        chk("stream_score", 32'(bus.score), 32'(m_score));

        for (int i = 0; i < 30; i++)
            do_event(1'($urandom), int'($urandom_range(0, 15)));

        // Clear during nibble 2 of an add.
        set_score(16'h0040);
        wait_ready();
        bus.evt_valid = 1'b1; bus.evt_sub = 1'b0; bus.evt_pts = 4'd5;
        @(posedge clk); @(negedge clk);
        bus.evt_valid = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        do_clear();
        dcount = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.done === 1'b1 || bus.sat === 1'b1) dcount++;
            @(posedge clk); @(negedge clk);
        end
        chk("clr_no_done", 32'(dcount), 32'd0);
        chk("clr_hold", 32'(bus.score), 32'd0);

        // Reset in the middle of an event.
        do_event(1'b0, 7);
        wait_ready();
        bus.evt_valid = 1'b1; bus.evt_sub = 1'b0; bus.evt_pts = 4'd3;
        @(posedge clk); @(negedge clk);
        bus.evt_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        m_score = 0;
        chk("mid_rst_ready", 32'(bus.evt_ready), 32'd1);
        chk("mid_rst_score", 32'(bus.score), 32'd0);
        dcount = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.done === 1'b1 || bus.sat === 1'b1) dcount++;
            @(posedge clk); @(negedge clk);
        end
        chk("mid_rst_no_done", 32'(dcount), 32'd0);
        do_event(1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/score_accum_serial.md
# score_accum_serial

Nibble-serial score accumulator for the game datapath. It accepts scoring events (award or penalty of 0–15 points) and updates an unsigned score register through the team's 4-bit ripple adder stage. The adder is instantiated beside this block: this block drives the adder's operand and carry-in ports and consumes its sum and carry-out. Results saturate at 0 and at full scale.

## Interface
Parameters:
- NIBBLES, 4, number of 4-bit digits in the score; score width W = 4*NIBBLES.

Ports:
- clk  input  1  single system clock; all state changes on rising edge
- rst_n  input  1  synchronous, active-low reset
- score_clr  input  1  synchronous clear of score; highest priority after reset
- evt_valid  input  1  event offered this cycle
- evt_ready  output  1  block can accept an event; high exactly when state is IDLE
- evt_sub  input  1  1 = penalty (subtract), 0 = award (add)
- evt_pts  input  4  point magnitude, zero-extended to W bits
- add_a  output  4  adder operand A (current score nibble)
- add_b  output  4  adder operand B (event nibble, inverted when subtracting)
- add_cin  output  1  adder carry-in
- add_s  input  4  adder sum
- add_cout  input  1  adder carry-out; the adder's overflow output is left unconnected
- score  output  W  committed score
- done  output  1  one-cycle pulse after each commit
- sat  output  1  one-cycle pulse, coincident with done, when the result clamped

## Operation
- States: IDLE, RUN. Nibble counter k = 0..NIBBLES-1 is valid in RUN.
- IDLE: evt_ready = 1; add_a, add_b and add_cin are driven to 0. On evt_valid & evt_ready:
  - latch evt_sub and the zero-extended operand;
  - set k = 0 and carry_reg = 0;
  - go to RUN.
- RUN, cycle k:
  - add_a = score[4k+3:4k];
  - add_b = op[4k+3:4k], inverted when sub = 1;
  - add_cin = sub when k = 0, else carry_reg.
  - At the edge: result[4k+3:4k] <= add_s, carry_reg <= add_cout, k <= k+1.
- Last nibble edge (k = NIBBLES-1) commits the score and returns to IDLE:
  - add with final cout = 1: score <= all ones, sat pulse;
  - sub with final cout = 0 (borrow): score <= 0, sat pulse;
  - otherwise score <= assembled result.
  - done pulses in the following cycle in either case.
- evt_pts = 0 still runs the full sequence; done pulses and score is unchanged.
- Inputs evt_sub and evt_pts are sampled only at accept; they are ignored in RUN.
- score_clr = 1 (any state):
  - score <= 0, state <= IDLE;
  - any in-flight event is discarded with no done and no sat;
  - an evt_valid in the same cycle is not accepted.
- rst_n = 0 at an edge: state IDLE, score 0, done 0, sat 0, carry_reg 0, k 0. evt_ready reads 1 from the first cycle after reset. Reset mid-RUN aborts silently.

## Timing
- Accept at edge E0. Nibbles are computed in cycles E0..E0+NIBBLES-1 and captured at edges E1..E4 (NIBBLES = 4).
- Score is updated at E4. done and sat are high in the cycle after E4.
- evt_ready is low for exactly NIBBLES cycles after accept. The earliest next accept is at E5, so back-to-back events are spaced NIBBLES+1 edges apart.
- The adder path is combinational within one cycle: add_a/add_b/add_cin to add_s/add_cout must settle before the next edge.
- done and sat are never high for more than one consecutive cycle per event.

## Test plan
- Reset, then add 9 → ready=1 before accept; after 5 edges score=0x0009, done pulses once, sat=0.
- Score 0x00FF, add 1 → carry ripples through nibbles 0–2; score=0x0100, sat=0.
- Score 0xFFF8, add 15 → score=0xFFFF, sat=1 with done. Then score 0x0003, subtract 5 → score=0x0000, sat=1.
- Score 0x1000, subtract 1 → borrow chain; score=0x0FFF, sat=0. Subtract 0 → score unchanged, done pulses.
- Hold evt_valid high continuously with add 1 → exactly one accept every 5 cycles; evt_ready low for 4 cycles each time; score increments by 1 per done.
- Assert score_clr at k=2 of an add → score=0, no done. Then assert rst_n=0 mid-RUN → IDLE, score=0, evt_ready=1 in the first cycle after release.
